muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative, parametrised multiply/divide unit with architectural HI/LO registers: the multi-cycle successor to the combinational multiply/divide paths of the CPU ALU. It executes signed/unsigned multiply and divide in WIDTH+1 cycles using shift-add and restoring shift-subtract datapaths. It also supports direct HI/LO writes and reports divide-by-zero. It sits beside the ALU in the execute stage, and the pipeline stalls on `busy`.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when idle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are reserved.
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
- divzero  out  1  valid with `done`; high if a DIV/DIVU had b == 0.
- hi  out  WIDTH  HI register (registered).
- lo  out  WIDTH  LO register (registered).

## Operation
- States: IDLE, CALC, FIX.
- busy = (state != IDLE).
- Reset values: state IDLE; hi, lo, done, divzero, busy and internal counter all 0.
- Acceptance:
  - `start` is accepted only in IDLE with op in 000–101.
  - On acceptance, a, b, op and the operand signs are captured, so inputs may change afterwards.
  - `start` while busy, or with reserved op, is ignored with no response.
- MTHI/MTLO:
  - Complete in IDLE: hi (or lo) ← a at the accepting edge.
  - done pulses next cycle with divzero = 0; state stays IDLE.
- MULT/MULTU:
  - IDLE→CALC. Operands are converted to magnitudes (signed op with a negative MSB → two's complement); unsigned ops use raw values.
  - CALC runs exactly WIDTH cycles, one shift-add step per cycle into a 2·WIDTH accumulator.
  - CALC→FIX. In FIX, the signed result is negated across 2·WIDTH bits if the operand signs differ; then {hi, lo} ← result.
- DIV/DIVU with b ≠ 0:
  - IDLE→CALC. CALC runs WIDTH restoring-division steps on magnitudes.
  - In FIX: lo ← quotient, hi ← remainder.
  - Signed only: quotient is negated if the signs differ; remainder is negated if the dividend is negative.
  - Most-negative / −1: lo = 100…0, hi = 0, with no error flag.
- DIV/DIVU with b == 0:
  - IDLE→FIX directly, skipping CALC.
  - FIX writes lo ← all ones, hi ← a (raw); divzero = 1 with done.
- FIX→IDLE always, with done = 1 registered for the following cycle.
- divzero holds its value only while done is high; otherwise it is 0.
- A new start may be accepted in the same cycle done is high.
- Reset mid-operation aborts the operation: no done, and HI/LO are cleared to 0.
- HI/LO change only at FIX completion, MTHI/MTLO, or reset.

## Timing
- Start accepted at edge E0.
- MULT/MULTU/DIV/DIVU (b ≠ 0):
  - CALC steps occur at E1..E_WIDTH; FIX completes at E_WIDTH+1.
  - done is high in the cycle after E_WIDTH+1, i.e. WIDTH+1 cycles after E0 (33 for WIDTH = 32).
  - busy is high for cycles E0+ … E_WIDTH+1−.
- Divide by zero: FIX completes at E1; done is high after E1 (1-cycle latency); busy is high for one cycle.
- MTHI/MTLO: write at E0; done is high after E0; busy stays low.
- Back-to-back operations: with start held high and op valid, the next operation is accepted on the edge that ends the done cycle (zero-bubble issue).
- No combinational path from inputs to outputs.

## Test plan
- MULT a = FFFFFFFD (−3), b = 00000005 → done 33 cycles after start; hi = FFFFFFFF, lo = FFFFFFF1; busy low the cycle done rises.
- MULTU a = b = FFFFFFFF → hi = FFFFFFFE, lo = 00000001; MULT with the same operands → hi = 00000000, lo = 00000001.
- DIV a = FFFFFFF9 (−7), b = 2 → lo = FFFFFFFD, hi = FFFFFFFF. DIVU with the same operands → lo = 7FFFFFFC, hi = 00000001. DIV 80000000 / FFFFFFFF → lo = 80000000, hi = 0, divzero = 0.
- DIVU a = 00001234, b = 0 → done 1 cycle after start; divzero = 1, hi = 00001234, lo = FFFFFFFF; busy high for exactly 1 cycle.
- MTLO a = CAFEF00D → lo = CAFEF00D at E0 and done the next cycle. A start issued 5 cycles into a MULT is ignored; the MULT result is unchanged.
- Reset asserted 10 cycles into a DIV → next cycle: busy = 0, hi = lo = 0, and no done. A fresh MULT 3×4 then gives lo = 0000000C.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one step per cycle, sign fix-up in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start is sampled only while IDLE with op 000..101; done is a
  // single-cycle pulse with hi/lo/divzero valid, and busy covers CALC and FIX.
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic [2:0]         op_q;
  logic               sdiff, aneg, dz;

  logic               accept, is_signed, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_top, div_diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, mul_res;
  logic [WIDTH-1:0]   quot, rem;

  assign accept    = (state == IDLE) && start && (op <= 3'b101);
  assign is_signed = ~op[0];
  assign b_zero    = (b == '0);
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign busy      = (state != IDLE);

  // Multiply: low half holds the multiplier and shifts out LSB-first.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // Divide: {remainder, quotient} shift left; quotient bits enter at the LSB.
  assign div_top  = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_top - {1'b0, opnd};
  assign div_nxt  = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign mul_res = sdiff ? -acc : acc;
  assign quot    = sdiff ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem     = aneg  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !op[2]) state_nxt = (op[1] && b_zero) ? FIX : CALC;
      end
      CALC: begin
        if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_raw   <= '0;
      op_q    <= '0;
      sdiff   <= 1'b0;
      aneg    <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= 1'b0;
      divzero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op;
            a_raw <= a;
            cnt   <= '0;
            sdiff <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            aneg  <= is_signed && a[WIDTH-1];
            dz    <= op[1] && !op[2] && b_zero;
            if (op == 3'b100) begin
              hi   <= a;
              done <= 1'b1;
            end else if (op == 3'b101) begin
              lo   <= a;
              done <= 1'b1;
            end else if (op[1]) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end
        end
        CALC: begin
          acc <= op_q[1] ? div_nxt : mul_nxt;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done    <= 1'b1;
          divzero <= dz;
          if (dz) begin
            lo <= {WIDTH{1'b1}};
            hi <= a_raw;
          end else if (op_q[1]) begin
            lo <= quot;
            hi <= rem;
          end else begin
            {hi, lo} <= mul_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH = 32) with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc, busy_cnt;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                         DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next edge E0; cyc = edges after E0 until done is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout op %0d observed no done expected done", o);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;

    run_op(MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    check("mult_lat", 64'(cyc), 64'd33);
    check("mult_busy_at_done", 64'(busy), 64'd0);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mult_divzero", 64'(divzero), 64'd0);
    @(posedge clk); #1;
    check("done_pulse_width", 64'(done), 64'd0);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mult_neg_neg", {hi, lo}, 64'h0000_0000_0000_0001);
    run_op(MULTU, 32'h0001_2345, 32'h0000_1000);
    check("multu_small", {hi, lo}, 64'h0000_0000_1234_5000);

    run_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_lat", 64'(cyc), 64'd33);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIVU, 32'hFFFF_FFF9, 32'h0000_0002);
    check("divu", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_minneg", {hi, lo}, 64'h0000_0000_8000_0000);
    check("div_minneg_dz", 64'(divzero), 64'd0);
    run_op(DIV, 32'h0000_0064, 32'hFFFF_FFF9);
    check("div_pos_negdiv", {hi, lo}, 64'h0000_0002_FFFF_FFF2);

    run_op(DIVU, 32'h0000_1234, 32'h0000_0000);
    check("dz_lat", 64'(cyc), 64'd1);
    check("dz_flag", 64'(divzero), 64'd1);
    check("dz_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    check("dz_busy_cycles", 64'(busy_cnt), 64'd1);
    @(posedge clk); #1;
    check("dz_flag_clears", 64'(divzero), 64'd0);

    run_op(MTLO, 32'hCAFE_F00D, 32'h0);
    check("mtlo_lat", 64'(cyc), 64'd0);
    check("mtlo_lo", 64'(lo), 64'h0000_0000_CAFE_F00D);
    check("mtlo_hi_kept", 64'(hi), 64'h0000_0000_0000_1234);
    check("mtlo_busy", 64'(busy), 64'd0);
    run_op(MTHI, 32'h1357_9BDF, 32'h0);
    check("mthi", {hi, lo}, 64'h1357_9BDF_CAFE_F00D);

    // Reserved op must be ignored entirely.
    @(negedge clk); start = 1'b1; op = 3'b110; a = 32'hDEAD_BEEF;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("rsvd_done", 64'(done), 64'd0);
    check("rsvd_busy", 64'(busy), 64'd0);
    check("rsvd_hilo", {hi, lo}, 64'h1357_9BDF_CAFE_F00D);

    // Start during a MULT is ignored; inputs changing after E0 do not matter.
    @(negedge clk); start = 1'b1; op = MULT; a = 32'h0000_0007; b = 32'hFFFF_FFFA;
    @(posedge clk); #1; start = 1'b0; a = 32'h5555_5555; b = 32'h1;
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; op = MTLO; a = 32'h0BAD_0BAD;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("busy_start_done", 64'(done), 64'd1);
    check("busy_start_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

    // Back-to-back: start held through done; the second op issues with no bubble.
    @(negedge clk); start = 1'b1; op = MULTU; a = 32'h0000_0003; b = 32'h0000_0005;
    @(posedge clk); #1;
    cyc = 0;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    op = MTHI; a = 32'h0000_ABCD;
    check("b2b_first", {hi, lo}, 64'h0000_0000_0000_000F);
    @(posedge clk); #1; start = 1'b0;
    check("b2b_second_hi", 64'(hi), 64'h0000_0000_0000_ABCD);
    check("b2b_second_done", 64'(done), 64'd1);

    // Reset mid-divide aborts with no done.
    @(negedge clk); start = 1'b1; op = DIV; a = 32'h0000_0064; b = 32'h0000_0007;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;
    busy_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) busy_cnt++;
    end
    check("rst_mid_no_done", 64'(busy_cnt), 64'd0);

    run_op(MULT, 32'h0000_0003, 32'h0000_0004);
    check("post_rst_mult", {hi, lo}, 64'h0000_0000_0000_000C);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
